// File: rtl/reg_bank128_n.sv
// reg_bank128_n: a 128-entry x n-bit storage bank with a registered read address.
// It feeds mux128to1_n: data_o drives the mux data inputs and sel_o drives the
// mux select. One write port, a one-cycle read-address register, and a
// self-timed bulk clear that zeroes one entry per cycle.
//
// Read handshake: rd_en_i is a one-cycle request with no ready/backpressure.
// A request sampled at edge k sets rd_valid_o for exactly cycle k+1. In that
// cycle sel_o holds the requested address, so the combinational mux output
// carries that entry's contents. Consumers sample the mux only while
// rd_valid_o=1.
module reg_bank128_n #(
  parameter int n       = 4,
  parameter int address = 7,
  localparam int m      = 2**address
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [address-1:0] wr_addr_i,
  input  logic [n-1:0]       wr_data_i,
  input  logic               rd_en_i,
  input  logic [address-1:0] rd_addr_i,
  input  logic               clr_i,
  output logic [n-1:0]       data_o [0:m-1],
  output logic [address-1:0] sel_o,
  output logic               rd_valid_o,
  output logic               busy_o,
  output logic [0:0]         state_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [address-1:0] LAST_ADDR = address'(m - 1);

  logic [n-1:0]       r_mem [0:m-1];
  logic [0:0]         r_state;
  logic [address-1:0] r_cnt;
  logic [address-1:0] r_sel;
  logic               r_rd_valid;

  // A write is taken only in IDLE. A clear request in the same cycle has priority.
  logic w_wr_take;
  assign w_wr_take = (r_state == S_IDLE) && wr_en_i && !clr_i;

  // Clear sequencer. IDLE waits for clr_i. CLEAR walks the counter from 0 to
  // m-1 and ignores clr_i, so a second pulse does not restart the walk.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array. Reset zeroes every entry. The clear walk zeroes entry[cnt].
  // A write lands only when it is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < m; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_take) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Read address register and valid flag. Reads are accepted in any state.
  // sel_o holds its value between requests.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sel      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        r_sel <= rd_addr_i;
      end
    end
  end

  assign data_o     = r_mem;
  assign sel_o      = r_sel;
  assign rd_valid_o = r_rd_valid;
  assign busy_o     = (r_state == S_CLEAR);
  assign state_o    = r_state;

endmodule
